// File: rtl/pipeline_ctrl_chain.sv
// Control-signal pipeline of DEPTH stages. Each stage holds a control vector,
// a destination register index and a valid bit. The hazard unit drives
// bubble, hold and flush. The block also keeps retire and stall counters and
// selects forwarding sources for two ID source registers.
module pipeline_ctrl_chain #(
    parameter int              CW       = 17,
    parameter int              DEPTH    = 4,
    parameter int              RDW      = 5,
    parameter int              RFEN_BIT = 0,
    parameter logic [CW-1:0]   NOP_CTRL = {CW{1'b0}},
    parameter int              FW       = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CW-1:0]          id_ctrl,
    input  logic [RDW-1:0]         id_rd,
    input  logic                   id_valid,
    input  logic                   bubble,
    input  logic [DEPTH-1:0]       hold,
    input  logic [DEPTH-1:0]       flush,
    input  logic [RDW-1:0]         rs1,
    input  logic [RDW-1:0]         rs2,
    output logic [DEPTH*CW-1:0]    stage_ctrl,
    output logic [DEPTH*RDW-1:0]   stage_rd,
    output logic [DEPTH-1:0]       stage_valid,
    output logic                   id_ready,
    output logic [FW-1:0]          occupancy,
    output logic [FW-1:0]          fwd1,
    output logic [FW-1:0]          fwd2,
    output logic [31:0]            retire_count,
    output logic [15:0]            stall_count
);

    logic [CW-1:0]    ctrl_q [DEPTH];
    logic [CW-1:0]    ctrl_d [DEPTH];
    logic [RDW-1:0]   rd_q   [DEPTH];
    logic [RDW-1:0]   rd_d   [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] h_s;
    logic [31:0]      retire_q;
    logic [15:0]      stall_q;

    // Returns 1-based index of the youngest stage that will write rs, else 0.
    function automatic logic [FW-1:0] fwd_sel(input logic [RDW-1:0] rs);
        logic [FW-1:0] sel;
        sel = '0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (valid_q[j] && ctrl_q[j][RFEN_BIT] && (rd_q[j] == rs) && (rs != '0)) begin
                sel = FW'(j + 1);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    // Effective hold: a stall freezes its own stage and everything upstream.
    always_comb begin
        h_s = '0;
        h_s[DEPTH-1] = hold[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            h_s[i] = hold[i] | h_s[i+1];
        end
    end

    // Next-state selection per stage: flush, then hold, then entry/shift.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ctrl_d[i]  = NOP_CTRL;
            rd_d[i]    = '0;
            valid_d[i] = 1'b0;
            if (flush[i]) begin
                ctrl_d[i]  = NOP_CTRL;
                rd_d[i]    = '0;
                valid_d[i] = 1'b0;
            end else if (h_s[i]) begin
                ctrl_d[i]  = ctrl_q[i];
                rd_d[i]    = rd_q[i];
                valid_d[i] = valid_q[i];
            end else if (i == 0) begin
                ctrl_d[i]  = bubble ? NOP_CTRL : id_ctrl;
                rd_d[i]    = bubble ? {RDW{1'b0}} : id_rd;
                valid_d[i] = id_valid & ~bubble;
            end else if (h_s[i-1]) begin
                // Upstream is frozen, so a bubble fills the gap below it.
                ctrl_d[i]  = NOP_CTRL;
                rd_d[i]    = '0;
                valid_d[i] = 1'b0;
            end else begin
                ctrl_d[i]  = ctrl_q[i-1];
                rd_d[i]    = rd_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // Stage registers and counters; reset forces NOP contents and zero counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= NOP_CTRL;
                rd_q[i]   <= '0;
            end
            valid_q  <= '0;
            retire_q <= 32'd0;
            stall_q  <= 16'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= ctrl_d[i];
                rd_q[i]   <= rd_d[i];
            end
            valid_q <= valid_d;
            if (valid_q[DEPTH-1] && !hold[DEPTH-1]) begin
                retire_q <= retire_q + 32'd1;
            end else begin
                retire_q <= retire_q;
            end
            if (h_s[0] && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end else begin
                stall_q <= stall_q;
            end
        end
    end

    // Occupancy is the number of valid stages.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + FW'(valid_q[i]);
        end
    end

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_pack
        assign stage_ctrl[g*CW +: CW]  = ctrl_q[g];
        assign stage_rd[g*RDW +: RDW]  = rd_q[g];
    end

    assign stage_valid  = valid_q;
    assign id_ready     = ~h_s[0];
    assign fwd1         = fwd_sel(rs1);
    assign fwd2         = fwd_sel(rs2);
    assign retire_count = retire_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl_chain.sv
// Self-checking bench for pipeline_ctrl_chain: directed scenarios plus a
// randomized run against a behavioural model of the stage chain.
module tb_pipeline_ctrl_chain;

    localparam int CW    = 17;
    localparam int DEPTH = 4;
    localparam int RDW   = 5;
    localparam int FW    = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic [CW-1:0]        id_ctrl;
    logic [RDW-1:0]       id_rd;
    logic                 id_valid;
    logic                 bubble;
    logic [DEPTH-1:0]     hold;
    logic [DEPTH-1:0]     flush;
    logic [RDW-1:0]       rs1;
    logic [RDW-1:0]       rs2;
    logic [DEPTH*CW-1:0]  stage_ctrl;
    logic [DEPTH*RDW-1:0] stage_rd;
    logic [DEPTH-1:0]     stage_valid;
    logic                 id_ready;
    logic [FW-1:0]        occupancy;
    logic [FW-1:0]        fwd1;
    logic [FW-1:0]        fwd2;
    logic [31:0]          retire_count;
    logic [15:0]          stall_count;

    int n_cmp  = 0;
    int n_fail = 0;

    pipeline_ctrl_chain #(.CW(CW), .DEPTH(DEPTH), .RDW(RDW)) dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_rd(id_rd),
        .id_valid(id_valid), .bubble(bubble), .hold(hold), .flush(flush),
        .rs1(rs1), .rs2(rs2), .stage_ctrl(stage_ctrl), .stage_rd(stage_rd),
        .stage_valid(stage_valid), .id_ready(id_ready), .occupancy(occupancy),
        .fwd1(fwd1), .fwd2(fwd2), .retire_count(retire_count),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: one slot per stage plus the two counters.
    typedef struct packed {
        logic           v;
        logic [CW-1:0]  c;
        logic [RDW-1:0] r;
    } slot_t;

    slot_t       m [DEPTH];
    int unsigned m_retire;
    int unsigned m_stall;

    function automatic bit frozen(input int i);
        // A stage is frozen when any stage at or below it in the chain holds.
        return |(hold >> i);
    endfunction

    function automatic int model_fwd(input logic [RDW-1:0] rs);
        if (rs == 0) return 0;
        for (int j = 0; j < DEPTH; j++)
            if (m[j].v && m[j].c[0] && m[j].r == rs) return j + 1;
        return 0;
    endfunction

    function automatic int model_occ();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m[i].v);
        return n;
    endfunction

    task automatic idle();
        id_ctrl = '0; id_rd = '0; id_valid = 1'b0; bubble = 1'b0;
        hold = '0; flush = '0; rs1 = '0; rs2 = '0;
    endtask

    // One rising edge: the model advances with the inputs seen at that edge.
    task automatic step();
        slot_t nx [DEPTH];
        slot_t nop;
        nop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush[i])                 nx[i] = nop;
            else if (frozen(i))           nx[i] = m[i];
            else if (i == 0)              nx[i] = bubble ? nop : slot_t'{id_valid, id_ctrl, id_rd};
            else if (frozen(i - 1))       nx[i] = nop;
            else                          nx[i] = m[i-1];
        end
        if (m[DEPTH-1].v && !hold[DEPTH-1]) m_retire = m_retire + 1;
        if ((|hold) && m_stall < 65535) m_stall = m_stall + 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) m[i] = nx[i];
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        m_retire = 0;
        m_stall  = 0;
    endtask

    task automatic feed(input logic [CW-1:0] c, input logic [RDW-1:0] r);
        id_valid = 1'b1; id_ctrl = c; id_rd = r; bubble = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (stage_valid !== '0 || stage_ctrl !== '0 || stage_rd !== '0) begin
            n_fail++;
            $display("FAIL reset_stages: got v=%b c=%h r=%h, want all zero", stage_valid, stage_ctrl, stage_rd);
        end
        n_cmp++;
        if (retire_count !== 32'd0 || stall_count !== 16'd0 || occupancy !== '0 || id_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_counters: got ret=%0d stall=%0d occ=%0d rdy=%b, want 0 0 0 1",
                     retire_count, stall_count, occupancy, id_ready);
        end
    endtask

    task automatic test_flow();
        int peak;
        do_reset();
        feed(17'h1ABCD, 5'd3);
        idle();
        peak = int'(occupancy);
        for (int k = 1; k <= DEPTH; k++) begin
            if (k > 1) step();
            if (int'(occupancy) > peak) peak = int'(occupancy);
            n_cmp++;
            if (stage_valid !== DEPTH'(1 << (k - 1)) || stage_ctrl[(k-1)*CW +: CW] !== 17'h1ABCD
                || stage_rd[(k-1)*RDW +: RDW] !== 5'd3) begin
                n_fail++;
                $display("FAIL flow_edge%0d: got v=%b c=%h r=%0d, want v=%b c=1abcd r=3", k, stage_valid,
                         stage_ctrl[(k-1)*CW +: CW], stage_rd[(k-1)*RDW +: RDW], DEPTH'(1 << (k - 1)));
            end
        end
        step();
        n_cmp++;
        if (retire_count !== 32'd1 || peak != 1 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL flow_retire: got ret=%0d peak=%0d occ=%0d, want 1 1 0", retire_count, peak, occupancy);
        end
    endtask

    task automatic test_bubble();
        do_reset();
        feed(17'h00101, 5'd1);
        id_valid = 1'b1; id_ctrl = 17'h00203; id_rd = 5'd2; bubble = 1'b1;
        step();
        n_cmp++;
        if (stage_valid[0] !== 1'b0 || stage_ctrl[0 +: CW] !== '0 || stage_rd[0 +: RDW] !== '0) begin
            n_fail++;
            $display("FAIL bubble_slot: got v=%b c=%h r=%0d, want 0 0 0", stage_valid[0], stage_ctrl[0 +: CW], stage_rd[0 +: RDW]);
        end
        feed(17'h00305, 5'd3);
        feed(17'h00407, 5'd4);
        idle();
        for (int k = 0; k < 6; k++) step();
        n_cmp++;
        if (retire_count !== 32'd3) begin
            n_fail++;
            $display("FAIL bubble_retire: got %0d, want 3", retire_count);
        end
    endtask

    task automatic fill4();
        for (int k = 1; k <= 4; k++) feed(CW'((k << 1) | 1), RDW'(k));
    endtask

    task automatic test_stall();
        do_reset();
        fill4();
        id_valid = 1'b1; id_ctrl = 17'h0000B; id_rd = 5'd5;
        hold = 4'b0010;
        #1;
        n_cmp++;
        if (id_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready: got %b, want 0", id_ready);
        end
        step();
        step();
        n_cmp++;
        if (stage_rd[0 +: RDW] !== 5'd4 || stage_rd[RDW +: RDW] !== 5'd3 || stage_valid[1:0] !== 2'b11) begin
            n_fail++;
            $display("FAIL stall_frozen: got rd0=%0d rd1=%0d v=%b, want 4 3 11", stage_rd[0 +: RDW], stage_rd[RDW +: RDW], stage_valid[1:0]);
        end
        n_cmp++;
        if (stage_valid[3:2] !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_bubbles: got v[3:2]=%b, want 00", stage_valid[3:2]);
        end
        n_cmp++;
        if (stall_count !== 16'd2 || retire_count !== 32'd2) begin
            n_fail++;
            $display("FAIL stall_counters: got stall=%0d ret=%0d, want 2 2", stall_count, retire_count);
        end
        idle();
    endtask

    task automatic test_flush_priority();
        do_reset();
        fill4();
        idle();
        hold = 4'b0100; flush = 4'b0100;
        step();
        n_cmp++;
        if (stage_valid[2] !== 1'b0 || stage_rd[2*RDW +: RDW] !== '0 || stage_valid[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stage2: got v=%b rd2=%0d, want v[3:2]=00 rd2=0", stage_valid, stage_rd[2*RDW +: RDW]);
        end
        n_cmp++;
        if (stage_rd[0 +: RDW] !== 5'd4 || stage_rd[RDW +: RDW] !== 5'd3 || stage_valid[1:0] !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_upstream: got rd0=%0d rd1=%0d v=%b, want 4 3 11", stage_rd[0 +: RDW], stage_rd[RDW +: RDW], stage_valid[1:0]);
        end
        idle();
    endtask

    task automatic test_forwarding();
        do_reset();
        feed(17'h00001, 5'd5);
        feed(17'h00001, 5'd7);
        feed(17'h00001, 5'd5);
        idle();
        rs1 = 5'd5; rs2 = 5'd0;
        #1;
        n_cmp++;
        if (fwd1 !== FW'(1) || fwd2 !== FW'(0)) begin
            n_fail++;
            $display("FAIL fwd_youngest: got fwd1=%0d fwd2=%0d, want 1 0", fwd1, fwd2);
        end
        rs2 = 5'd7;
        #1;
        n_cmp++;
        if (fwd2 !== FW'(2)) begin
            n_fail++;
            $display("FAIL fwd_rs2: got %0d, want 2", fwd2);
        end
        do_reset();
        feed(17'h00001, 5'd5);
        feed(17'h00001, 5'd7);
        feed(17'h00010, 5'd5);
        idle();
        rs1 = 5'd5;
        #1;
        n_cmp++;
        if (fwd1 !== FW'(3)) begin
            n_fail++;
            $display("FAIL fwd_rfen_off: got %0d, want 3", fwd1);
        end
        idle();
    endtask

    task automatic test_random();
        logic [DEPTH*CW-1:0]  ec;
        logic [DEPTH*RDW-1:0] er;
        logic [DEPTH-1:0]     ev;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_ctrl  = CW'($urandom);
            id_rd    = RDW'($urandom_range(0, 7));
            bubble   = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < DEPTH; i++) begin
                hold[i]  = ($urandom_range(0, 9) == 0);
                flush[i] = ($urandom_range(0, 15) == 0);
            end
            rs1 = RDW'($urandom_range(0, 7));
            rs2 = RDW'($urandom_range(0, 7));
            #1;
            n_cmp++;
            if (id_ready !== !frozen(0) || int'(fwd1) != model_fwd(rs1) || int'(fwd2) != model_fwd(rs2)
                || int'(occupancy) != model_occ()) begin
                n_fail++;
                $display("FAIL rand_comb@%0d: got rdy=%b f1=%0d f2=%0d occ=%0d, want %b %0d %0d %0d", n,
                         id_ready, fwd1, fwd2, occupancy, !frozen(0), model_fwd(rs1), model_fwd(rs2), model_occ());
            end
            step();
            for (int i = 0; i < DEPTH; i++) begin
                ec[i*CW +: CW]   = m[i].c;
                er[i*RDW +: RDW] = m[i].r;
                ev[i]            = m[i].v;
            end
            n_cmp++;
            if (stage_ctrl !== ec || stage_rd !== er || stage_valid !== ev
                || retire_count !== m_retire || 32'(stall_count) !== m_stall) begin
                n_fail++;
                $display("FAIL rand_state@%0d: got v=%b c=%h r=%h ret=%0d st=%0d, want v=%b c=%h r=%h ret=%0d st=%0d",
                         n, stage_valid, stage_ctrl, stage_rd, retire_count, stall_count, ev, ec, er, m_retire, m_stall);
            end
        end
        idle();
    endtask

    task automatic test_stall_saturate();
        do_reset();
        hold = 4'b0001;
        for (int n = 0; n < 66000; n++) step();
        n_cmp++;
        if (stall_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_saturate: got %h, want ffff", stall_count);
        end
        step();
        n_cmp++;
        if (stall_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stall_hold_max: got %h, want ffff", stall_count);
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        fill4();
        feed(17'h00011, 5'd9);
        n_cmp++;
        if (retire_count !== 32'd1 || stage_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL pre_reset_state: got ret=%0d v=%b, want 1 1111", retire_count, stage_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (stage_valid !== '0 || stage_ctrl !== '0 || stage_rd !== '0 || retire_count !== 32'd0
            || stall_count !== 16'd0 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b c=%h r=%h ret=%0d st=%0d occ=%0d, want all zero",
                     stage_valid, stage_ctrl, stage_rd, retire_count, stall_count, occupancy);
        end
        do_reset();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_flow();
        test_bubble();
        test_stall();
        test_flush_priority();
        test_forwarding();
        test_random();
        test_stall_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl_chain.md
Name: pipeline_ctrl_chain

Overview:
Parametrised control-signal pipeline that replaces the fixed ID/EX, EX/MEM and MEM/WB control registers with one DEPTH-stage chain.
- Each stage carries a control vector, a destination-register index and a valid bit.
- Supports bubble insertion at entry, per-stage hold with backward stall propagation, and per-stage flush.
- Provides retire/stall counters and forwarding-source selection for two source registers.
- Sits between the control unit and the stage datapaths; the hazard unit drives hold/flush/bubble.

Parameters:
CW, 17, control vector width
DEPTH, 4, number of stage registers (stage 0 = first after ID), min 2
RDW, 5, destination-register index width
RFEN_BIT, 0, bit of the control vector that is register-file write enable
NOP_CTRL, {CW{1'b0}}, control vector loaded for bubbles, flush and reset
FW, $clog2(DEPTH+1), forwarding-select width (derived)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
id_ctrl  input  CW  control vector from control unit
id_rd  input  RDW  destination register of ID instruction
id_valid  input  1  ID holds a real instruction
bubble  input  1  force NOP into stage 0 (control-unit mux select)
hold  input  DEPTH  per-stage hold request
flush  input  DEPTH  per-stage kill of the entering instruction
rs1, rs2  input  RDW  ID source registers for forwarding lookup
stage_ctrl  output  DEPTH*CW  flattened; stage i at [i*CW +: CW]
stage_rd  output  DEPTH*RDW  flattened, same packing
stage_valid  output  DEPTH  valid bit per stage
id_ready  output  1  stage 0 will accept this cycle
occupancy  output  FW  popcount of stage_valid
fwd1, fwd2  output  FW  forwarding select for rs1/rs2
retire_count  output  32  instructions leaving last stage
stall_count  output  16  cycles with stage 0 held

Behaviour:
- Reset, asynchronous and immediate, regardless of any in-flight state:
  - every stage_valid = 0, stage_ctrl = NOP_CTRL, stage_rd = 0;
  - retire_count = 0, stall_count = 0.
- Effective hold: h[DEPTH-1] = hold[DEPTH-1]; h[i] = hold[i] | h[i+1]. A stall freezes the stalled stage and everything upstream.
- id_ready = ~h[0]. Combinational.
- Per-stage update on the rising edge, in priority order:
  1. flush[i]: load bubble (valid 0, NOP_CTRL, rd 0). Flush beats hold.
  2. else h[i]: keep contents.
  3. else i == 0:
     - ctrl = bubble ? NOP_CTRL : id_ctrl;
     - rd = bubble ? 0 : id_rd;
     - valid = id_valid & ~bubble.
  4. else h[i-1] = 1: load bubble. The upstream stage is frozen, so the bubble enters the gap below the stall.
  5. else: load stage i-1 contents as they were before the edge.
- Flushing stage i does not stop stage i+1 capturing the old stage i contents. To kill an instruction in flight, flush the stage it moves into.
- Latency: an ID instruction reaches stage k after k+1 edges with no hold/flush.
- retire_count:
  - +1 on each edge where stage_valid[DEPTH-1] = 1 and hold[DEPTH-1] = 0;
  - wraps from 0xFFFFFFFF to 0.
- stall_count:
  - +1 on each edge where h[0] = 1;
  - saturates at 0xFFFF and holds there.
- occupancy: combinational popcount of stage_valid, range 0..DEPTH.
- Forwarding (combinational from registered state):
  - fwdN = j+1 for the lowest stage j with stage_valid[j] & stage_ctrl[j][RFEN_BIT] & (stage_rd[j] == rsN) & (rsN != 0);
  - otherwise 0;
  - the youngest producer wins.
- Simultaneous flush and hold on the same stage: flush wins; upstream still sees h from hold.
- All outputs are glitch-free registered values except id_ready, occupancy and fwd1/fwd2.

Test Plan:
- Flow, DEPTH=4: reset, then id_valid=1 with id_ctrl=0x1ABCD, id_rd=3, no hold, for one cycle -> appears in stage 0..3 on edges 1..4; retire_count=1 after edge 5; occupancy peaks at 1.
- Bubble: stream 4 instructions, bubble=1 on the 2nd -> stage 0 shows valid 0 / NOP_CTRL for that slot; retire_count=3.
- Stall: fill the pipe, assert hold[1] for 2 cycles ->
  - stages 0,1 frozen; id_ready=0; stall_count=2;
  - stage 2 receives 2 bubbles;
  - stage 3 keeps draining, so retire_count keeps counting.
- Flush priority: hold[2]=1 and flush[2]=1 on the same edge -> stage 2 becomes valid 0; stages 0,1 frozen.
- Forwarding: stage 0 rd=5 with RFEN=1, stage 2 rd=5 with RFEN=1 -> rs1=5 gives fwd1=1. With rs2=0 -> fwd2=0. With stage 0 RFEN=0 -> fwd1=3.
- Counters and reset:
  - preload hold[0]=1 for 70000 cycles -> stall_count=0xFFFF;
  - reset asserted mid-stream between edges -> all outputs return to reset values immediately.
